pong_ball_engine: RTL and testbench
===================================

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 SHALL have parameter BAR1_X, default 20: left x-coordinate of paddle 1.
REQ-002 SHALL have parameter BAR2_X, default 620: left x-coordinate of paddle 2.
REQ-003 SHALL have parameters BAR_W=4, BAR_H=60, BALL_SIZE=8 and SPEED=2 (pixels per frame), plus SERVE_FRAMES=60.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RST_BTN, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-007 SHALL have ports yBar1 and yBar2, input, 10 bits each: paddle top y-coordinates.
REQ-008 SHALL have port ball_x, output, 10 bits: ball top-left x, registered.
REQ-009 SHALL have port ball_y, output, 9 bits: ball top-left y, registered.
REQ-010 SHALL have ports score1 and score2, output, 4 bits each: registered goal counters.
REQ-011 SHALL have port goal, output, 1 bit: one-cycle pulse when either score changes.

Function
REQ-012 SHALL use FSM states WAIT, STEP, COMMIT and SERVE; the field is 640x480 and the ball occupies [x, x+BALL_SIZE-1] by [y, y+BALL_SIZE-1].
REQ-013 SHALL move WAIT->STEP on frame_tick, latching yBar1 and yBar2 in that cycle; STEP->COMMIT unconditionally; COMMIT->WAIT, or ->SERVE on a goal.
REQ-014 SHALL ignore frame_tick in STEP and COMMIT; ball_x and ball_y change only in COMMIT, so they are visible 2 cycles after the tick.
REQ-015 SHALL handle vertical motion: moving up with y<SPEED gives y=0 and dy=down; moving down with y+SPEED+BALL_SIZE>480 gives y=480-BALL_SIZE and dy=up; otherwise y=y±SPEED.
REQ-016 SHALL bounce off paddle 1 when: moving left, x>=BAR1_X+BAR_W, x-SPEED<BAR1_X+BAR_W, and y+BALL_SIZE>yBar1 and y<yBar1+BAR_H (latched values); result x=BAR1_X+BAR_W, dx=right.
REQ-017 SHALL bounce off paddle 2 symmetrically: moving right, x+BALL_SIZE<=BAR2_X, x+SPEED+BALL_SIZE>BAR2_X, with vertical overlap; result x=BAR2_X-BALL_SIZE, dx=left.
REQ-018 SHALL, with no paddle hit, set x=x±SPEED, except as in REQ-019.
REQ-019 SHALL score goals at the edges: moving left with x<SPEED increments score2; moving right with x+SPEED+BALL_SIZE>640 increments score1; either pulses goal for 1 cycle in COMMIT and enters SERVE.
REQ-020 SHALL apply vertical and horizontal rules in the same frame when both trigger (corner bounce).
REQ-021 SHALL let scores wrap 15->0.
REQ-022 SHALL handle SERVE: place ball at (316,236), set dx toward the player who conceded and keep dy, count SERVE_FRAMES frame_ticks, then enter WAIT.
REQ-023 SHALL perform all arithmetic at 11 bits, unsigned, with no intermediate wrap; comparisons precede subtraction, so there is no underflow.

Reset
REQ-024 SHALL, on RST_BTN=0 at a CLK edge, set state=SERVE, serve counter=0, ball=(316,236), dx=right, dy=down, scores=0, goal=0.
REQ-025 SHALL let reset override any state, including mid-STEP/COMMIT and mid-serve; no partial update survives.

Configuration
REQ-026 SHALL, with macro BALL_SPEEDUP_EN defined, hold a 3-bit speed register (reset and serve value SPEED) incremented by 1 per paddle hit, saturating at 6; this register replaces SPEED in REQ-015 to REQ-019.
REQ-027 SHALL, without BALL_SPEEDUP_EN, use constant SPEED and generate no speed register.

Verification
REQ-028 SHALL cover: reset, then 60 ticks -> ball=(316,236) throughout, goal never asserted, then motion starts at (318,238).
REQ-029 SHALL cover: ball at y=1 moving up, tick -> y=0, dy=down; next tick -> y=2.
REQ-030 SHALL cover: ball x=25, moving left, y=100, yBar1=80, tick -> x=24, dx=right, score unchanged.
REQ-031 SHALL cover: ball x=1, moving left, yBar1=300, tick -> score2=1, goal high exactly 1 cycle, ball=(316,236), dx=left.
REQ-032 SHALL cover: second frame_tick 1 cycle after first -> ignored, single 2-pixel step only.
REQ-033 SHALL cover: RST_BTN low during COMMIT cycle -> reset values next cycle, no goal pulse.

Source files
------------

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: frame-stepped ball motion, paddle bounce and scoring.
// Optional BALL_SPEEDUP_EN: ball gains one pixel/frame per paddle hit.
module pong_ball_engine #(
  parameter int BAR1_X       = 20,
  parameter int BAR2_X       = 620,
  parameter int BAR_W        = 4,
  parameter int BAR_H        = 60,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       frame_tick,
  input  logic [9:0] yBar1,
  input  logic [9:0] yBar2,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       goal
);

  localparam logic [1:0] WAIT   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] SERVE  = 2'd3;

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  localparam logic [10:0] FW  = 11'd640;
  localparam logic [10:0] FH  = 11'd480;
  localparam logic [10:0] BS  = 11'(BALL_SIZE);
  localparam logic [10:0] BH  = 11'(BAR_H);
  localparam logic [10:0] P1R = 11'(BAR1_X + BAR_W);
  localparam logic [10:0] P2L = 11'(BAR2_X);
  localparam logic [9:0]  SX  = 10'd316;
  localparam logic [8:0]  SY  = 9'd236;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    x;
  logic [8:0]    y;
  logic          dx;
  logic          dy;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [9:0]    yb1;
  logic [9:0]    yb2;

  logic [9:0] nx_q;
  logic [8:0] ny_q;
  logic       ndx_q;
  logic       ndy_q;
  logic       g1_q;
  logic       g2_q;

  logic [10:0] spd;
  logic [10:0] xe;
  logic [10:0] ye;
  logic [10:0] b1e;
  logic [10:0] b2e;
  logic        ov1;
  logic        ov2;
  logic        p1_hit;
  logic        p2_hit;
  logic        g1_hit;
  logic        g2_hit;

  logic [9:0] c_x;
  logic [8:0] c_y;
  logic       c_dx;
  logic       c_dy;

  assign xe  = {1'b0, x};
  assign ye  = {2'b0, y};
  assign b1e = {1'b0, yb1};
  assign b2e = {1'b0, yb2};

  assign ov1 = (ye + BS > b1e) && (ye < b1e + BH);
  assign ov2 = (ye + BS > b2e) && (ye < b2e + BH);

  // Subtractions rewritten as additions on the other side: no underflow.
  assign p1_hit = !dx && (xe >= P1R) && (xe < P1R + spd) && ov1;
  assign p2_hit = dx && (xe + BS <= P2L) && (xe + spd + BS > P2L) && ov2;
  assign g2_hit = !dx && !p1_hit && (xe < spd);
  assign g1_hit = dx && !p2_hit && (xe + spd + BS > FW);

  always_comb begin
    c_y  = y;
    c_dy = dy;
    c_x  = x;
    c_dx = dx;
    if (!dy) begin
      if (ye < spd) begin
        c_y  = 9'd0;
        c_dy = 1'b1;
      end else begin
        c_y = 9'(ye - spd);
      end
    end else if (ye + spd + BS > FH) begin
      c_y  = 9'(FH - BS);
      c_dy = 1'b0;
    end else begin
      c_y = 9'(ye + spd);
    end
    unique case (1'b1)
      p1_hit: begin
        c_x  = 10'(P1R);
        c_dx = 1'b1;
      end
      p2_hit: begin
        c_x  = 10'(P2L - BS);
        c_dx = 1'b0;
      end
      g1_hit, g2_hit: c_x = x;
      default: c_x = dx ? 10'(xe + spd) : 10'(xe - spd);
    endcase
  end

  always_ff @(posedge CLK) begin
    goal <= 1'b0;
    if (!RST_BTN) begin
      state <= SERVE;
      cnt   <= '0;
      x     <= SX;
      y     <= SY;
      dx    <= 1'b1;
      dy    <= 1'b1;
      s1    <= 4'd0;
      s2    <= 4'd0;
      yb1   <= 10'd0;
      yb2   <= 10'd0;
      nx_q  <= SX;
      ny_q  <= SY;
      ndx_q <= 1'b1;
      ndy_q <= 1'b1;
      g1_q  <= 1'b0;
      g2_q  <= 1'b0;
    end else begin
      unique case (state)
        WAIT: begin
          if (frame_tick) begin
            yb1   <= yBar1;
            yb2   <= yBar2;
            state <= STEP;
          end
        end
        STEP: begin
          nx_q  <= c_x;
          ny_q  <= c_y;
          ndx_q <= c_dx;
          ndy_q <= c_dy;
          g1_q  <= g1_hit;
          g2_q  <= g2_hit;
          state <= COMMIT;
        end
        COMMIT: begin
          dy <= ndy_q;
          if (g1_q || g2_q) begin
            s1    <= s1 + {3'd0, g1_q};
            s2    <= s2 + {3'd0, g2_q};
            goal  <= 1'b1;
            x     <= SX;
            y     <= SY;
            // Serve toward whoever just conceded.
            dx    <= g1_q;
            cnt   <= '0;
            state <= SERVE;
          end else begin
            x     <= nx_q;
            y     <= ny_q;
            dx    <= ndx_q;
            state <= WAIT;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [2:0] spd_q;
  logic       hit_q;

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      spd_q <= 3'(SPEED);
      hit_q <= 1'b0;
    end else begin
      if (state == STEP) hit_q <= p1_hit | p2_hit;
      if (state == COMMIT) begin
        if (g1_q || g2_q) spd_q <= 3'(SPEED);
        else if (hit_q && spd_q != 3'd6) spd_q <= spd_q + 3'd1;
      end
    end
  end

  assign spd = {8'd0, spd_q};
`else
  assign spd = 11'(SPEED);
`endif

  assign ball_x = x;
  assign ball_y = y;
  assign score1 = s1;
  assign score2 = s2;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed checks on a default instance and on a
// BALL_SIZE=7 instance whose odd clamp/bounce positions reach odd coordinates.
module tb_pong_ball_engine;

  logic       CLK = 1'b0;
  logic       RST_BTN = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] a_ybar1 = 10'd1000;
  logic [9:0] a_ybar2 = 10'd1000;
  logic [9:0] b_ybar1 = 10'd1000;
  logic [9:0] b_ybar2 = 10'd1000;
  logic [9:0] a_x, b_x;
  logic [8:0] a_y, b_y;
  logic [3:0] a_s1, a_s2, b_s1, b_s2;
  logic       a_goal, b_goal;

  int n_run = 0;
  int n_fail = 0;
  int a_goal_cnt = 0;
  int b_goal_cnt = 0;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (a_goal) a_goal_cnt++;
    if (b_goal) b_goal_cnt++;
  end

  pong_ball_engine u_a (
    .CLK(CLK), .RST_BTN(RST_BTN), .frame_tick(frame_tick),
    .yBar1(a_ybar1), .yBar2(a_ybar2),
    .ball_x(a_x), .ball_y(a_y),
    .score1(a_s1), .score2(a_s2), .goal(a_goal)
  );

  pong_ball_engine #(
    .BALL_SIZE(7), .SERVE_FRAMES(2)
  ) u_b (
    .CLK(CLK), .RST_BTN(RST_BTN), .frame_tick(frame_tick),
    .yBar1(b_ybar1), .yBar2(b_ybar2),
    .ball_x(b_x), .ball_y(b_y),
    .score1(b_s1), .score2(b_s2), .goal(b_goal)
  );

  task automatic do_reset();
    @(negedge CLK);
    RST_BTN = 1'b0;
    frame_tick = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_BTN = 1'b1;
  endtask

  // Returns on the negedge after the COMMIT edge: new values visible.
  task automatic tick();
    @(negedge CLK);
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_BTN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_run++;
    if (a_x !== 10'd316 || a_y !== 9'd236) begin
      $display("FAIL reset_a_pos: got (%0d,%0d) want (316,236)", a_x, a_y);
      n_fail++;
    end
    n_run++;
    if (a_s1 !== 4'd0 || a_s2 !== 4'd0 || a_goal !== 1'b0) begin
      $display("FAIL reset_a_score: got %0d/%0d goal %0b want 0/0 0",
               a_s1, a_s2, a_goal);
      n_fail++;
    end
    n_run++;
    if (b_x !== 10'd316 || b_y !== 9'd236) begin
      $display("FAIL reset_b_pos: got (%0d,%0d) want (316,236)", b_x, b_y);
      n_fail++;
    end
    RST_BTN = 1'b1;
  endtask

  task automatic test_serve();
    int g0;
    int bad;
    do_reset();
    g0 = a_goal_cnt;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (a_x !== 10'd316 || a_y !== 9'd236) bad++;
    end
    n_run++;
    if (bad != 0) begin
      $display("FAIL serve_hold: %0d ticks moved the ball, want 0", bad);
      n_fail++;
    end
    n_run++;
    if (a_goal_cnt != g0) begin
      $display("FAIL serve_goal: got %0d pulses want 0", a_goal_cnt - g0);
      n_fail++;
    end
    tick();
    n_run++;
    if (a_x !== 10'd318 || a_y !== 9'd238) begin
      $display("FAIL serve_first_move: got (%0d,%0d) want (318,238)",
               a_x, a_y);
      n_fail++;
    end
  endtask

  task automatic test_double_tick();
    @(negedge CLK);
    frame_tick = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    frame_tick = 1'b0;
    @(negedge CLK);
    n_run++;
    if (a_x !== 10'd320 || a_y !== 9'd240) begin
      $display("FAIL double_tick: got (%0d,%0d) want (320,240)", a_x, a_y);
      n_fail++;
    end
    repeat (4) @(negedge CLK);
    n_run++;
    if (a_x !== 10'd320 || a_y !== 9'd240) begin
      $display("FAIL double_tick_hold: got (%0d,%0d) want (320,240)",
               a_x, a_y);
      n_fail++;
    end
  endtask

  task automatic test_wall_paddle();
    b_ybar1 = 10'd150;
    b_ybar2 = 10'd400;
    do_reset();
    run(2 + 354);
    tick();
    n_run++;
    if (b_x !== 10'd201 || b_y !== 9'd1) begin
      $display("FAIL top_pre: got (%0d,%0d) want (201,1)", b_x, b_y);
      n_fail++;
    end
    tick();
    n_run++;
    if (b_x !== 10'd199 || b_y !== 9'd0) begin
      $display("FAIL top_clamp: got (%0d,%0d) want (199,0)", b_x, b_y);
      n_fail++;
    end
    tick();
    n_run++;
    if (b_x !== 10'd197 || b_y !== 9'd2) begin
      $display("FAIL top_rebound: got (%0d,%0d) want (197,2)", b_x, b_y);
      n_fail++;
    end
    run(86);
    n_run++;
    if (b_x !== 10'd25 || b_y !== 9'd174) begin
      $display("FAIL paddle_pre: got (%0d,%0d) want (25,174)", b_x, b_y);
      n_fail++;
    end
    tick();
    n_run++;
    if (b_x !== 10'd24 || b_y !== 9'd176) begin
      $display("FAIL paddle_hit: got (%0d,%0d) want (24,176)", b_x, b_y);
      n_fail++;
    end
    n_run++;
    if (b_s1 !== 4'd0 || b_s2 !== 4'd0 || b_goal !== 1'b0) begin
      $display("FAIL paddle_score: got %0d/%0d goal %0b want 0/0 0",
               b_s1, b_s2, b_goal);
      n_fail++;
    end
    tick();
    n_run++;
    if (b_x !== 10'd26 || b_y !== 9'd178) begin
      $display("FAIL paddle_away: got (%0d,%0d) want (26,178)", b_x, b_y);
      n_fail++;
    end
  endtask

  task automatic test_goal();
    b_ybar1 = 10'd300;
    b_ybar2 = 10'd400;
    do_reset();
    run(2 + 455);
    n_run++;
    if (b_x !== 10'd1 || b_y !== 9'd198) begin
      $display("FAIL goal_pre: got (%0d,%0d) want (1,198)", b_x, b_y);
      n_fail++;
    end
    tick();
    n_run++;
    if (b_goal !== 1'b1 || b_s2 !== 4'd1 || b_s1 !== 4'd0) begin
      $display("FAIL goal_score: got goal %0b s1 %0d s2 %0d want 1 0 1",
               b_goal, b_s1, b_s2);
      n_fail++;
    end
    n_run++;
    if (b_x !== 10'd316 || b_y !== 9'd236) begin
      $display("FAIL goal_serve_pos: got (%0d,%0d) want (316,236)",
               b_x, b_y);
      n_fail++;
    end
    @(negedge CLK);
    n_run++;
    if (b_goal !== 1'b0) begin
      $display("FAIL goal_width: got %0b want 0", b_goal);
      n_fail++;
    end
    run(2);
    tick();
    n_run++;
    if (b_x !== 10'd314 || b_y !== 9'd238) begin
      $display("FAIL goal_serve_dir: got (%0d,%0d) want (314,238)",
               b_x, b_y);
      n_fail++;
    end
  endtask

  task automatic test_reset_commit();
    int g0;
    b_ybar1 = 10'd300;
    b_ybar2 = 10'd400;
    do_reset();
    run(2 + 455);
    g0 = b_goal_cnt;
    @(negedge CLK);
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    @(negedge CLK);
    RST_BTN = 1'b0;
    @(negedge CLK);
    n_run++;
    if (b_goal !== 1'b0 || b_s2 !== 4'd0 || b_goal_cnt != g0) begin
      $display("FAIL rst_commit_goal: got goal %0b s2 %0d want 0 0",
               b_goal, b_s2);
      n_fail++;
    end
    n_run++;
    if (b_x !== 10'd316 || b_y !== 9'd236) begin
      $display("FAIL rst_commit_pos: got (%0d,%0d) want (316,236)",
               b_x, b_y);
      n_fail++;
    end
    RST_BTN = 1'b1;
    run(3);
    n_run++;
    if (b_x !== 10'd318 || b_y !== 9'd238) begin
      $display("FAIL rst_commit_resume: got (%0d,%0d) want (318,238)",
               b_x, b_y);
      n_fail++;
    end
  endtask

  task automatic test_score_wrap();
    b_ybar1 = 10'd1000;
    b_ybar2 = 10'd1000;
    do_reset();
    for (int g = 1; g <= 16; g++) begin
      run(160);
      n_run++;
      if (b_s1 !== 4'(g - 1) || b_goal !== 1'b0) begin
        $display("FAIL wrap_pre_%0d: got s1 %0d goal %0b want %0d 0",
                 g, b_s1, b_goal, (g - 1) % 16);
        n_fail++;
      end
      tick();
      n_run++;
      if (b_goal !== 1'b1 || b_s1 !== 4'(g) || b_s2 !== 4'd0) begin
        $display("FAIL wrap_goal_%0d: got goal %0b s1 %0d s2 %0d want 1 %0d 0",
                 g, b_goal, b_s1, b_s2, g % 16);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_double_tick();
    test_wall_paddle();
    test_goal();
    test_reset_commit();
    test_score_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
